ysyx_210247_mem_stage: RTL
==========================

// Module: ysyx_210247_mem_stage
// PURPOSE
//  MEM stage of the 5-stage RV64 core. Sits between reg_exe_mem and reg_mem_wb.
//  - Consumes mem_valid_in / exe_to_mem_bus_i; produces mem_allow_in back to reg_exe_mem.
//  - Runs a single-outstanding request/response transaction on the data-memory port for loads and stores.
//  - Aligns store data into strobes; extracts and extends load data; emits the MEM->WB bus.
// PARAMETERS
//  EXE_TO_MEM_BUS  299  input bus width: {pc64,inst32,rd5,rd_wen,mem_ren,mem_wen,funct3[3],addr64,sdata64,alu64}
//  MEM_TO_WB_BUS   166  output bus width: {pc64,inst32,rd5,rd_wen,wb_data64}
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    asynchronous active-low reset
//  mem_valid_in     in   1    reg_exe_mem holds a valid instruction
//  exe_to_mem_bus_i in   299  instruction payload, stable while mem_allow_in=0
//  mem_allow_in     out  1    stage accepts a new instruction this cycle
//  mem_valid_out    out  1    valid result on mem_to_wb_bus_o
//  mem_to_wb_bus_o  out  166  result payload to reg_mem_wb
//  mem_allow_out    in   1    reg_mem_wb can accept (wb_allow_in)
//  dmem_req         out  1    memory request valid
//  dmem_ready       in   1    request accepted when dmem_req && dmem_ready
//  dmem_we          out  1    1 = store, 0 = load
//  dmem_addr        out  64   address, 8-byte aligned ({addr[63:3],3'b0})
//  dmem_wdata       out  64   store data shifted by addr[2:0]*8
//  dmem_wstrb       out  8    byte strobes; 0 for loads
//  dmem_rvalid      in   1    response (load data or store ack); sampled only in WAIT_RESP
//  dmem_rdata       in   64   load data, whole aligned doubleword
//  mem_misalign_o   out  1    misaligned-access flag, valid with mem_valid_out
// BEHAVIOUR
//  - Reset: state=IDLE, load-data register=0, dmem_req=0, mem_valid_out=0, mem_misalign_o=0; mem_allow_in=mem_allow_out.
//  - is_mem = mem_ren | mem_wen (from the bus).
//  - IDLE, !mem_valid_in or !is_mem: pass-through, zero latency.
//    mem_valid_out=mem_valid_in; mem_allow_in=mem_allow_out; wb_data=alu.
//  - IDLE, mem_valid_in && is_mem: dmem_req=1 combinationally; mem_allow_in=0; mem_valid_out=0.
//    On dmem_ready -> WAIT_RESP; otherwise stay IDLE with the request held.
//  - WAIT_RESP: dmem_req=0. On dmem_rvalid: capture dmem_rdata -> HOLD. Stores also wait for rvalid.
//  - HOLD: mem_valid_out=1, wb_data = extended load data (loads) or alu (stores).
//    Stores force rd_wen=0. mem_allow_in=mem_allow_out; on mem_allow_out -> IDLE.
//  - Minimum memory-op latency: req accepted at cycle 0, rvalid at cycle 1, result valid at cycle 2.
//  - Load extension by funct3, bytes selected by addr[2:0]:
//    000 LB sext8, 001 LH sext16, 010 LW sext32, 011 LD, 100 LBU, 101 LHU, 110 LWU zext.
//  - Store strobes: SB/SH/SW/SD (funct3 000..011) -> wstrb = ((1<<(1<<f3))-1) << addr[2:0], truncated to 8 bits.
//  - dmem_rvalid outside WAIT_RESP and dmem_ready outside the IDLE request are ignored.
//  - Reset mid-transaction returns to IDLE and drops the in-flight response; the interconnect is reset together with the core.
//  - Single outstanding transaction; no flush input. Flushes kill upstream registers only, and an accepted memory op always completes.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - Misaligned access: LH/SH addr[0]!=0, LW/SW addr[1:0]!=0, LD/SD addr[2:0]!=0.
//   - IDLE issues no dmem_req and goes straight to HOLD with mem_misalign_o=1 and rd_wen=0.
//  MEM_MISALIGN_TRAP_EN undefined:
//   - Low address bits below the access size are ignored (natural alignment forced).
//   - mem_misalign_o tied to 0.
// STRUCTURE
//  - defines.v: bus widths, bus field offsets, funct3 encodings, state encodings (IDLE/WAIT_RESP/HOLD).
//  - Sub-module ysyx_210247_lsu_align (combinational): store shift/strobe generation and load select/extend.
//  - This module holds the FSM and the load-data register only.
// TESTING
//  - Non-mem ALU op, alu=0x1234, mem_allow_out=1 -> same-cycle mem_valid_out=1, wb_data=0x1234, mem_allow_in=1.
//  - LB addr=0x...1003, rdata=0x00000000_80000000 -> byte 3 = 0x80 -> wb_data=0xFFFF_FFFF_FFFF_FF80.
//    LBU at the same address -> wb_data=0x80.
//  - SH addr=0x...2006, sdata=0xBEEF, dmem_ready held 0 for 3 cycles -> dmem_req held 4 cycles, wstrb=0xC0,
//    wdata[63:48]=0xBEEF; after rvalid: mem_valid_out with rd_wen=0.
//  - LD in HOLD with mem_allow_out=0 for 2 cycles -> mem_valid_out and bus stable, mem_allow_in=0; released on allow.
//  - rst_n low during WAIT_RESP, then rvalid after release -> state IDLE, no mem_valid_out, rvalid ignored.
//  - With the macro, LW addr=0x...1002 -> no dmem_req; next cycle mem_valid_out=1, mem_misalign_o=1.
//    Without the macro -> access at 0x...1000, wstrb=0x00.

Source files
------------

// File: rtl/ysyx_210247_mem_stage_pkg.sv
// ysyx_210247_mem_stage_pkg: bus layouts, funct3 encodings and FSM states for the MEM stage.
package ysyx_210247_mem_stage_pkg;

    localparam int EXE_TO_MEM_BUS = 299;
    localparam int MEM_TO_WB_BUS  = 166;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] alu;
    } exe_to_mem_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] wb_data;
    } mem_to_wb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        HOLD      = 2'd2
    } mem_state_e;

    function automatic logic [7:0] strb_mask(input logic [1:0] sz);
        return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
    endfunction

endpackage

// File: rtl/ysyx_210247_mem_stage_if.sv
// ysyx_210247_mem_stage_if: single-outstanding request/response data-memory port.
interface ysyx_210247_mem_stage_if;
    logic        req;
    logic        ready;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        rvalid;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ready, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/ysyx_210247_lsu_align.sv
// ysyx_210247_lsu_align: store shift/strobe generation and load byte select/extension.
// MEM_MISALIGN_TRAP_EN enables the misaligned-access flag; otherwise natural alignment is forced.
module ysyx_210247_lsu_align
    import ysyx_210247_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        mem_wen,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] sdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] ldata,
    output logic        misalign
);
    logic [2:0]  lo_mask;
    logic [2:0]  off;
    logic [63:0] sh;

    // Offset bits below the access size are dropped, giving a naturally aligned lane.
    assign lo_mask = 3'b111 << funct3[1:0];
    assign off     = addr_lo & lo_mask;
    assign wdata   = sdata << {off, 3'b000};
    assign wstrb   = mem_wen ? strb_mask(funct3[1:0]) << off : 8'h00;
    assign sh      = rdata >> {off, 3'b000};

    always_comb begin
        ldata = funct3 == F3_B  ? {{56{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{48{sh[15]}}, sh[15:0]} :
                funct3 == F3_W  ? {{32{sh[31]}}, sh[31:0]} :
                funct3 == F3_BU ? {56'h0, sh[7:0]} :
                funct3 == F3_HU ? {48'h0, sh[15:0]} :
                funct3 == F3_WU ? {32'h0, sh[31:0]} : sh;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = |(addr_lo & ~lo_mask);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_210247_mem_stage.sv
// ysyx_210247_mem_stage: MEM stage FSM (IDLE/WAIT_RESP/HOLD) and load-data register.
// MEM_MISALIGN_TRAP_EN: misaligned accesses skip memory and complete with mem_misalign_o=1.
module ysyx_210247_mem_stage
    import ysyx_210247_mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_valid_in,
    input  logic [EXE_TO_MEM_BUS-1:0] exe_to_mem_bus_i,
    output logic                      mem_allow_in,
    output logic                      mem_valid_out,
    output logic [MEM_TO_WB_BUS-1:0]  mem_to_wb_bus_o,
    input  logic                      mem_allow_out,
    ysyx_210247_mem_stage_if.master   dmem,
    output logic                      mem_misalign_o
);
    exe_to_mem_t bus;
    mem_to_wb_t  wb;
    mem_state_e  state_q, state_d;
    logic [63:0] ldata_q, ldata_d;
    logic        mis_q, mis_d;
    logic        is_mem;
    logic        misalign;
    logic [63:0] ld_ext;
    logic [63:0] wb_data;
    logic        rd_wen;

    assign bus    = exe_to_mem_t'(exe_to_mem_bus_i);
    assign is_mem = bus.mem_ren | bus.mem_wen;

    ysyx_210247_lsu_align u_align (
        .funct3   (bus.funct3),
        .mem_wen  (bus.mem_wen),
        .addr_lo  (bus.addr[2:0]),
        .sdata    (bus.sdata),
        .rdata    (ldata_q),
        .wdata    (dmem.wdata),
        .wstrb    (dmem.wstrb),
        .ldata    (ld_ext),
        .misalign (misalign)
    );

    assign dmem.we        = bus.mem_wen;
    assign dmem.addr      = {bus.addr[63:3], 3'b000};
    assign mem_misalign_o = state_q == HOLD && mis_q;

    always_comb begin
        state_d       = state_q;
        ldata_d       = ldata_q;
        mis_d         = mis_q;
        dmem.req      = 1'b0;
        mem_allow_in  = mem_allow_out;
        mem_valid_out = 1'b0;
        wb_data       = bus.alu;
        rd_wen        = bus.rd_wen;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_in && is_mem) begin
                    mem_allow_in = 1'b0;
                    mis_d        = misalign;
                    if (misalign) begin
                        state_d = HOLD;
                    end else begin
                        dmem.req = 1'b1;
                        state_d  = dmem.ready ? WAIT_RESP : IDLE;
                    end
                end else begin
                    mem_valid_out = mem_valid_in;
                end
            end
            WAIT_RESP: begin
                mem_allow_in = 1'b0;
                if (dmem.rvalid) begin
                    ldata_d = dmem.rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                mem_valid_out = 1'b1;
                wb_data       = bus.mem_ren && !mis_q ? ld_ext : bus.alu;
                rd_wen        = bus.rd_wen & ~bus.mem_wen & ~mis_q;
                state_d       = mem_allow_out ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb = '{pc: bus.pc, inst: bus.inst, rd: bus.rd, rd_wen: rd_wen, wb_data: wb_data};
    end

    assign mem_to_wb_bus_o = wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ldata_q <= 64'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ldata_q <= ldata_d;
            mis_q   <= mis_d;
        end
    end

endmodule
